// File: rtl/atomic_counter_reader.sv
// Initiator for the atomic 64-bit counter read protocol. One atomic request
// returns the low half and makes the responder latch the high half. The
// non-atomic request that immediately follows returns that latched high half.
// The coherent result is presented together with the delta from the previous
// good sample. Optional auto-sampling issues a read every SAMPLE_PERIOD idle
// cycles.
module atomic_counter_reader #(
    parameter int unsigned SAMPLE_PERIOD = 0,
    parameter int unsigned PERIOD_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_start_i,
    output logic        req_o,
    output logic        atomic_o,
    input  logic        ack_i,
    input  logic [31:0] count_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [63:0] value_o,
    output logic [63:0] delta_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        CAP  = 2'd3
    } state_t;

    // Period counter value on which the auto-sample tick fires.
    localparam logic [PERIOD_W-1:0] LAST_TICK =
        PERIOD_W'((SAMPLE_PERIOD == 0) ? 0 : SAMPLE_PERIOD - 1);

    state_t              state_q, state_d;
    logic [31:0]         lo_q, lo_d;
    logic                fail_q, fail_d;
    logic [63:0]         prev_q, prev_d;
    logic [63:0]         value_q, value_d;
    logic [63:0]         delta_q, delta_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                tick_q, tick_d;
    logic                req_q, req_d;
    logic                atomic_q, atomic_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                start;
    logic [63:0]         sample;

    // Next-state, capture, auto-sample and registered-output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d  = state_q;
        lo_d     = lo_q;
        fail_d   = fail_q;
        prev_d   = prev_q;
        value_d  = value_q;
        delta_d  = delta_q;
        period_d = period_q;
        tick_d   = 1'b0;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        start    = rd_start_i | tick_q;
        sample   = {count_i, lo_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LO;
                    fail_d  = 1'b0;
                end
            end
            LO: begin
                // HI must follow LO back-to-back or the responder drops its latched upper half.
                state_d = HI;
            end
            HI: begin
                if (ack_i) lo_d = count_i;
                else       fail_d = 1'b1;
                state_d = CAP;
            end
            CAP: begin
                state_d = IDLE;
                if (fail_q || !ack_i) begin
                    err_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    value_d = sample;
                    delta_d = sample - prev_q;
                    prev_d  = sample;
                end
            end
            default: state_d = IDLE;
        endcase

        // Period counter runs only while idle with no start pending.
        if (SAMPLE_PERIOD == 0 || state_q != IDLE || start) begin
            period_d = '0;
        end else if (period_q == LAST_TICK) begin
            period_d = '0;
            tick_d   = 1'b1;
        end else begin
            period_d = period_q + PERIOD_W'(1);
        end

        req_d    = (state_d == LO) || (state_d == HI);
        atomic_d = (state_d == LO);
        busy_d   = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            fail_q   <= 1'b0;
            prev_q   <= '0;
            value_q  <= '0;
            delta_q  <= '0;
            period_q <= '0;
            tick_q   <= 1'b0;
            req_q    <= 1'b0;
            atomic_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            lo_q     <= lo_d;
            fail_q   <= fail_d;
            prev_q   <= prev_d;
            value_q  <= value_d;
            delta_q  <= delta_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            req_q    <= req_d;
            atomic_q <= atomic_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign req_o    = req_q;
    assign atomic_o = atomic_q;
    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;
    assign value_o  = value_q;
    assign delta_o  = delta_q;

endmodule

// File: tb/tb_atomic_counter_reader.sv
// Bench for atomic_counter_reader: a responder model, a per-cycle reference
// model and directed reads with literal expectations. A second instance runs
// in auto-sample mode.
module tb_atomic_counter_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_start = 1'b0;
    logic        req_o, atomic_o, busy_o, valid_o, err_o;
    logic        ack = 1'b0;
    logic [31:0] count = '0;
    logic [63:0] value_o, delta_o;

    logic        req_a, atomic_a, busy_a, valid_a, err_a;
    logic        ack_a = 1'b0;
    logic [31:0] count_a = '0;
    logic [63:0] value_a, delta_a;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    atomic_counter_reader #(.SAMPLE_PERIOD(0), .PERIOD_W(16)) dut (
        .clk(clk), .reset(reset), .rd_start_i(rd_start),
        .req_o(req_o), .atomic_o(atomic_o), .ack_i(ack), .count_i(count),
        .busy_o(busy_o), .valid_o(valid_o), .err_o(err_o),
        .value_o(value_o), .delta_o(delta_o)
    );

    atomic_counter_reader #(.SAMPLE_PERIOD(8), .PERIOD_W(16)) dut_auto (
        .clk(clk), .reset(reset), .rd_start_i(1'b0),
        .req_o(req_a), .atomic_o(atomic_a), .ack_i(ack_a), .count_i(count_a),
        .busy_o(busy_a), .valid_o(valid_a), .err_o(err_a),
        .value_o(value_a), .delta_o(delta_a)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder for the main instance. The counter is loaded by the stimulus
    // through ld_val/ld_en and otherwise advances by ctr_step each cycle.
    logic [63:0] ctr = '0;
    logic [63:0] ctr_step = '0;
    logic [63:0] ld_val = '0;
    logic        ld_en = 1'b0;
    logic        drop_lo = 1'b0;
    logic        drop_hi = 1'b0;
    logic [31:0] hi_latch = '0;
    logic [63:0] seq_snap = '0;
    logic        seq_err = 1'b0;
    logic        r_req, r_atom;

    always @(posedge clk) begin
        r_req  = req_o;
        r_atom = atomic_o;
        #1;
        if (r_req && r_atom) begin
            ack      = !drop_lo;
            count    = ctr[31:0];
            hi_latch = ctr[63:32];
            seq_snap = ctr;
            seq_err  = drop_lo;
        end else if (r_req) begin
            ack   = !drop_hi;
            count = hi_latch;
            if (drop_hi) seq_err = 1'b1;
        end else begin
            ack   = 1'b0;
            count = 32'hDEAD_BEEF;
        end
        if (ld_en) ctr = ld_val;
        else       ctr = ctr + ctr_step;
    end

    // Responder for the auto-sampling instance: counter advances by 3 each cycle.
    logic [63:0] ctr_a = 64'h0000_0000_FFFF_FF00;
    logic [31:0] hi_a = '0;
    logic        ra_req, ra_atom;

    always @(posedge clk) begin
        ra_req  = req_a;
        ra_atom = atomic_a;
        #1;
        ack_a = ra_req;
        if (ra_req && ra_atom) begin
            count_a = ctr_a[31:0];
            hi_a    = ctr_a[63:32];
        end else if (ra_req) begin
            count_a = hi_a;
        end else begin
            count_a = 32'h0BAD_F00D;
        end
        ctr_a = ctr_a + 64'd3;
    end

    // Reference model: a read accepted while idle occupies the next three
    // cycles and its result appears in the fourth; requests go out in the
    // first two of those cycles, the first one atomic.
    int          m_age = -1;
    logic        m_req = 1'b0, m_atomic = 1'b0, m_busy = 1'b0;
    logic        m_valid = 1'b0, m_err = 1'b0;
    logic [63:0] m_value = '0, m_delta = '0, m_prev = '0;

    always @(posedge clk) begin
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (reset) begin
            m_age   = -1;
            m_value = '0;
            m_delta = '0;
            m_prev  = '0;
        end else if (m_age < 0) begin
            if (rd_start) m_age = 0;
        end else begin
            m_age++;
            if (m_age == 3) begin
                m_age = -1;
                if (seq_err) begin
                    m_err = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    m_delta = seq_snap - m_prev;
                    m_value = seq_snap;
                    m_prev  = seq_snap;
                end
            end
        end
        m_busy   = (m_age >= 0);
        m_req    = (m_age == 0) || (m_age == 1);
        m_atomic = (m_age == 0);
        #1;
        check("cyc req",    64'(req_o),    64'(m_req));
        check("cyc atomic", 64'(atomic_o), 64'(m_atomic));
        check("cyc busy",   64'(busy_o),   64'(m_busy));
        check("cyc valid",  64'(valid_o),  64'(m_valid));
        check("cyc err",    64'(err_o),    64'(m_err));
        check("cyc value",  value_o,       m_value);
        check("cyc delta",  delta_o,       m_delta);
    end

    // Load the counter, set drop flags, start at cycle T, return at negedge of T+4.
    task automatic do_read(input logic [63:0] ld, input logic dl, input logic dh, input logic [63:0] step);
        @(negedge clk);
        ld_val   = ld;
        ld_en    = 1'b1;
        ctr_step = step;
        drop_lo  = dl;
        drop_hi  = dh;
        @(negedge clk);
        ld_en    = 1'b0;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_valid_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        time  t_last;

        repeat (3) @(negedge clk);
        check("rst valid", 64'(valid_o), 64'd0);
        check("rst busy",  64'(busy_o),  64'd0);
        check("rst req",   64'(req_o),   64'd0);
        check("rst value", value_o,      64'd0);
        check("rst delta", delta_o,      64'd0);
        reset = 1'b0;

        // Auto-sample instance: results every 12 cycles, delta = 12 * 3.
        wait_valid_a(ok);
        check("auto first valid seen", 64'(ok), 64'd1);
        t_last = $time;
        for (int k = 0; k < 3; k++) begin
            wait_valid_a(ok);
            check("auto valid seen", 64'(ok), 64'd1);
            check("auto interval", 64'(($time - t_last) / 10), 64'd12);
            check("auto delta", delta_a, 64'd36);
            check("auto err", 64'(err_a), 64'd0);
            t_last = $time;
        end

        // Test 1: first read, delta equals value.
        @(negedge clk);
        ld_val = 64'h0000_0001_FFFF_FFFE;
        ld_en  = 1'b1;
        ctr_step = '0;
        @(negedge clk);
        ld_en    = 1'b0;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check("t1 req T+1",    64'(req_o),    64'd1);
        check("t1 atomic T+1", 64'(atomic_o), 64'd1);
        @(negedge clk);
        check("t1 req T+2",    64'(req_o),    64'd1);
        check("t1 atomic T+2", 64'(atomic_o), 64'd0);
        @(negedge clk);
        check("t1 req T+3",    64'(req_o),    64'd0);
        check("t1 valid T+3",  64'(valid_o),  64'd0);
        @(negedge clk);
        check("t1 valid T+4",  64'(valid_o),  64'd1);
        check("t1 value",      value_o, 64'h0000_0001_FFFF_FFFE);
        check("t1 delta",      delta_o, 64'h0000_0001_FFFF_FFFE);

        // Test 2: counter advanced by 0x10.
        do_read(64'h0000_0002_0000_000E, 1'b0, 1'b0, 64'd0);
        check("t2 valid", 64'(valid_o), 64'd1);
        check("t2 value", value_o, 64'h0000_0002_0000_000E);
        check("t2 delta", delta_o, 64'h10);

        // Coherent carry: counter ticks across bit 31 between the two requests.
        do_read(64'h0000_0002_FFFF_FFFE, 1'b0, 1'b0, 64'd1);
        check("carry value", value_o, 64'h0000_0002_FFFF_FFFF);
        check("carry delta", delta_o, 64'h0000_0000_FFFF_FFF1);

        // Test 3: missing upper-half ack, then missing lower-half ack.
        do_read(64'h0000_0009_0000_0000, 1'b0, 1'b1, 64'd0);
        check("t3 err",   64'(err_o),   64'd1);
        check("t3 valid", 64'(valid_o), 64'd0);
        check("t3 value", value_o, 64'h0000_0002_FFFF_FFFF);
        check("t3 delta", delta_o, 64'h0000_0000_FFFF_FFF1);
        do_read(64'h0000_0009_0000_0000, 1'b1, 1'b0, 64'd0);
        check("t3b err",   64'(err_o), 64'd1);
        check("t3b value", value_o, 64'h0000_0002_FFFF_FFFF);
        @(negedge clk);
        drop_lo = 1'b0;
        drop_hi = 1'b0;

        // Delta wraps modulo 2**64 when the counter reads lower.
        do_read(64'h5, 1'b0, 1'b0, 64'd0);
        check("wrap value", value_o, 64'h5);
        check("wrap delta", delta_o, 64'hFFFF_FFFD_0000_0006);

        // Test 4: starts while busy are dropped; start with the valid pulse is taken.
        @(negedge clk);
        ld_val = 64'h0000_0000_0000_0105;
        ld_en  = 1'b1;
        @(negedge clk);
        ld_en    = 1'b0;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        @(negedge clk);
        rd_start = 1'b1;
        @(negedge clk);
        check("t4 busy T+3", 64'(busy_o), 64'd1);
        @(negedge clk);
        check("t4 valid T+4", 64'(valid_o), 64'd1);
        check("t4 value", value_o, 64'h105);
        check("t4 delta", delta_o, 64'h100);
        @(negedge clk);
        rd_start = 1'b0;
        check("t4 req T+5",    64'(req_o),    64'd1);
        check("t4 atomic T+5", 64'(atomic_o), 64'd1);
        repeat (4) @(negedge clk);
        check("t4 second idle", 64'(busy_o), 64'd0);

        // Test 6: reset mid-sequence discards the sample.
        @(negedge clk);
        ld_val = 64'h0000_0007_0000_0007;
        ld_en  = 1'b1;
        @(negedge clk);
        ld_en    = 1'b0;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6 req",   64'(req_o),  64'd0);
        check("t6 busy",  64'(busy_o), 64'd0);
        repeat (4) @(negedge clk);
        check("t6 value", value_o, 64'd0);
        check("t6 delta", delta_o, 64'd0);

        // Fresh read after reset: prev was cleared so delta equals value.
        do_read(64'h0000_0000_0000_1234, 1'b0, 1'b0, 64'd0);
        check("post value", value_o, 64'h1234);
        check("post delta", delta_o, 64'h1234);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
